tx_frame_sequencer: RTL and testbench
=====================================

# tx_frame_sequencer

Sequences one transmit frame out of the shared 1000-byte message RAM into the modulator byte interface. Starts on a rising edge of the control block's `transmit` register bit and fetches `msg_length` bytes from address 0 upward. Hands each byte to the modulator with a valid/ready handshake, then pulses `o_tx_done` so the control block clears `transmit`. Also arbitrates the single RAM read port against host SPI accesses; the host always wins.

## Interface
Parameters:
- `ADDR_W`, 10, RAM address width.
- `MAX_LEN`, 1000, RAM size in bytes; longer lengths are clamped to this.
- `SYNC_WORD`, 16'hD391, frame sync pattern, used only under `TX_SEQ_SYNC_WORD_EN`.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `reset_n`  in  1  asynchronous, active-low reset.
- `i_transmit`  in  1  transmit request level from the control register.
- `i_msg_length`  in  10  payload length in bytes; sampled at frame start.
- `i_host_ram_req`  in  1  host SPI is using the RAM port this cycle.
- `o_ram_rd`  out  1  RAM read strobe.
- `o_ram_addr`  out  ADDR_W  RAM read address.
- `i_ram_data`  in  8  RAM read data, valid one cycle after `o_ram_rd`.
- `o_byte`  out  8  byte to the modulator.
- `o_byte_valid`  out  1  `o_byte` is valid.
- `i_byte_ready`  in  1  modulator accepts the byte.
- `o_tx_done`  out  1  one-cycle pulse at frame end.
- `o_busy`  out  1  high in every state except IDLE.

## Operation
- States: IDLE, SYNC (only with the macro), FETCH, WAIT, PRESENT, DONE.
- IDLE:
  - Register `i_transmit` into `tx_d`.
  - Start condition: `i_transmit & ~tx_d`.
  - On start, latch `len = min(i_msg_length, MAX_LEN)` and clear `idx`.
  - Next state on start: SYNC if enabled; else DONE if `len==0`; else FETCH.
- FETCH:
  - `o_ram_rd = ~i_host_ram_req`, `o_ram_addr = idx`.
  - If `i_host_ram_req` is high, stay in FETCH and retry. The host has strict priority.
  - Otherwise go to WAIT.
- WAIT: capture `i_ram_data` into the `o_byte` register, then go to PRESENT.
- PRESENT:
  - `o_byte_valid = 1` and `o_byte` is held stable until `i_byte_ready` is sampled high.
  - On accept: if `idx == len-1`, go to DONE; else increment `idx` and go to FETCH.
- DONE: `o_tx_done = 1` for exactly one cycle, then go to IDLE.
- Abort: if `i_transmit` is sampled low in any state other than IDLE or DONE:
  - Return to IDLE next cycle.
  - `o_byte_valid` drops immediately and no `o_tx_done` pulse is issued.
  - A byte being presented is discarded.
- Re-arm: a new frame requires `i_transmit` low, then high. A level held high after DONE never restarts a frame.
- Width rules:
  - `idx` and `len` are 10 bits; `idx` never exceeds `len-1`.
  - `o_ram_addr` is driven as 0 outside FETCH.
- Reset (async assert, synchronous deassert upstream): state IDLE, `tx_d=0`, `o_byte=8'h00`, `idx=0`, `len=0`. All outputs are 0.

## Timing
- Start edge sampled at clock edge N: FETCH is active in cycle N+1 with `o_ram_rd=1`, `o_ram_addr=0` (no sync, no host conflict).
- RAM read latency is 1 cycle. The byte is visible on `o_byte` with valid in cycle N+3.
- Per-byte minimum is 3 cycles (FETCH, WAIT, PRESENT with ready high). Each cycle of host conflict or ready-low adds one cycle.
- `o_tx_done` is asserted in the cycle after the last accept; `o_busy` is low the cycle after that.
- `len==0` with no sync: `o_tx_done` in cycle N+1, no RAM reads, no bytes.
- Same-cycle events:
  - `i_host_ram_req` and FETCH: the host wins and `o_ram_rd=0`.
  - Abort and `i_byte_ready` in PRESENT: abort wins, and the byte is counted as not sent.
- `o_ram_rd` and `o_byte_valid` are never asserted in the same cycle.

## Configuration
- `TX_SEQ_SYNC_WORD_EN` defined:
  - SYNC state emits `SYNC_WORD[15:8]`, then `SYNC_WORD[7:0]` through the same valid/ready handshake. These bytes make no RAM access.
  - After the sync bytes, go to FETCH, or to DONE if `len==0`.
  - The start-to-first-byte latency becomes N+2.
- Undefined: no SYNC state; the frame carries payload bytes only.

## Test plan
- `len=3`, RAM[0..2]=11,22,33, ready tied high -> `o_byte` sequence 11,22,33, `o_tx_done` pulse one cycle after the 3rd accept, total 10 cycles from the start edge to done.
- `len=2` with `i_host_ram_req` high for 4 cycles at the first FETCH -> `o_ram_rd` stays 0 for those 4 cycles, the first byte is delayed 4 cycles, data is unchanged.
- Ready low for 5 cycles while presenting byte 0xAB -> `o_byte_valid` and 0xAB are held stable all 5 cycles, exactly one accept.
- `i_transmit` dropped during byte 2 of 5 -> IDLE next cycle, no `o_tx_done`; a new edge restarts the frame from address 0.
- `len=0`, and `len=1023` -> done with zero bytes; exactly 1000 bytes read (address 999 last), then done.
- `TX_SEQ_SYNC_WORD_EN`, `len=1` -> bytes D3, 91, then RAM[0], then `o_tx_done`; held-high `i_transmit` does not restart the frame.

Source files
------------

// File: rtl/tx_frame_sequencer.sv
// -----------------------------------------------------------------------------
// tx_frame_sequencer
//
// Purpose:
//   Streams one transmit frame out of the shared message RAM to the modulator.
//   A rising edge on i_transmit starts the frame. Bytes 0..len-1 are fetched
//   one at a time and handed over with a valid/ready handshake. A one-cycle
//   o_tx_done pulse then lets the control block clear its transmit bit.
//   The single RAM read port is shared with the host SPI, and the host always
//   wins it.
//
// Optional feature:
//   `TX_SEQ_SYNC_WORD_EN -- when defined, SYNC_WORD[15:8] and SYNC_WORD[7:0]
//   are presented ahead of the payload. These two bytes need no RAM access.
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   i_transmit          transmit request level (rising edge starts a frame,
//                       low level aborts a running frame)
//   i_msg_length        payload length in bytes, sampled at frame start
//   i_host_ram_req      host owns the RAM port this cycle
//   o_ram_rd/o_ram_addr RAM read strobe and address
//   i_ram_data          RAM read data, one cycle after o_ram_rd
//   o_byte/o_byte_valid byte to the modulator and its valid flag
//   i_byte_ready        modulator accepts the presented byte
//   o_tx_done           one-cycle pulse at the end of a completed frame
//   o_busy              high whenever the sequencer is not idle
// -----------------------------------------------------------------------------
module tx_frame_sequencer #(
   parameter int unsigned ADDR_W    = 10,
   parameter int unsigned MAX_LEN   = 1000,
   parameter logic [15:0] SYNC_WORD = 16'hD391
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              i_transmit,
   input  logic [9:0]        i_msg_length,
   input  logic              i_host_ram_req,
   output logic              o_ram_rd,
   output logic [ADDR_W-1:0] o_ram_addr,
   input  logic [7:0]        i_ram_data,
   output logic [7:0]        o_byte,
   output logic              o_byte_valid,
   input  logic              i_byte_ready,
   output logic              o_tx_done,
   output logic              o_busy
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
`ifdef TX_SEQ_SYNC_WORD_EN
      S_SYNC    = 3'd5,
`endif
      S_FETCH   = 3'd1,
      S_WAIT    = 3'd2,
      S_PRESENT = 3'd3,
      S_DONE    = 3'd4
   } state_e;

   localparam logic [9:0] MAX_LEN_L = 10'(MAX_LEN);

   state_e     state_q, state_d;
   logic       tx_dly_q, tx_dly_d;   // i_transmit delayed one cycle, for edge detect
   logic [9:0] len_q, len_d;
   logic [9:0] idx_q, idx_d;
   logic [7:0] byte_q, byte_d;
   logic       start;
   logic       abort;

`ifdef TX_SEQ_SYNC_WORD_EN
   // 0: first sync byte pending, 1: second sync byte pending, 2: payload
   logic [1:0] sync_cnt_q, sync_cnt_d;
`else
   // The sync word is only consumed when the preamble is compiled in.
   logic [15:0] unused_sync_word;
   assign unused_sync_word = SYNC_WORD;
`endif

   always_comb begin
      // NOTE: every always_comb target gets a default first, so no path leaves
      // one unassigned and infers a latch.
      state_d      = state_q;
      tx_dly_d     = i_transmit;
      len_d        = len_q;
      idx_d        = idx_q;
      byte_d       = byte_q;
`ifdef TX_SEQ_SYNC_WORD_EN
      sync_cnt_d   = sync_cnt_q;
`endif
      o_ram_rd     = 1'b0;
      o_ram_addr   = '0;
      o_byte_valid = 1'b0;
      o_tx_done    = 1'b0;
      start        = i_transmit & ~tx_dly_q;
      abort        = ~i_transmit & (state_q != S_IDLE) & (state_q != S_DONE);

      case (state_q)
         S_IDLE: begin
            if (start) begin
               len_d = (i_msg_length > MAX_LEN_L) ? MAX_LEN_L : i_msg_length;
               idx_d = '0;
`ifdef TX_SEQ_SYNC_WORD_EN
               sync_cnt_d = 2'd0;
               state_d    = S_SYNC;
`else
               state_d = (len_d == 10'd0) ? S_DONE : S_FETCH;
`endif
            end
         end
`ifdef TX_SEQ_SYNC_WORD_EN
         // Load the pending sync byte into the output register; it is
         // presented next cycle exactly like a payload byte.
         S_SYNC: begin
            byte_d  = sync_cnt_q[0] ? SYNC_WORD[7:0] : SYNC_WORD[15:8];
            state_d = S_PRESENT;
         end
`endif
         S_FETCH: begin
            o_ram_rd   = ~i_host_ram_req;
            o_ram_addr = ADDR_W'(idx_q);
            if (!i_host_ram_req) state_d = S_WAIT;
         end
         S_WAIT: begin
            byte_d  = i_ram_data;
            state_d = S_PRESENT;
         end
         S_PRESENT: begin
            // Gated by i_transmit so an abort in this cycle is never seen as
            // a completed handshake by the modulator.
            o_byte_valid = i_transmit;
            if (i_byte_ready) begin
`ifdef TX_SEQ_SYNC_WORD_EN
               if (sync_cnt_q != 2'd2) begin
                  sync_cnt_d = sync_cnt_q + 2'd1;
                  if (sync_cnt_q == 2'd0) state_d = S_SYNC;
                  else                    state_d = (len_q == 10'd0) ? S_DONE : S_FETCH;
               end else
`endif
               if (idx_q == len_q - 10'd1) begin
                  state_d = S_DONE;
               end else begin
                  idx_d   = idx_q + 10'd1;
                  state_d = S_FETCH;
               end
            end
         end
         S_DONE: begin
            o_tx_done = 1'b1;
            state_d   = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // Abort overrides any handshake or progress decided above.
      if (abort) state_d = S_IDLE;
   end

   assign o_byte = byte_q;
   assign o_busy = (state_q != S_IDLE);

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         tx_dly_q   <= 1'b0;
         len_q      <= '0;
         idx_q      <= '0;
         byte_q     <= 8'h00;
`ifdef TX_SEQ_SYNC_WORD_EN
         sync_cnt_q <= 2'd0;
`endif
      end else begin
         state_q    <= state_d;
         tx_dly_q   <= tx_dly_d;
         len_q      <= len_d;
         idx_q      <= idx_d;
         byte_q     <= byte_d;
`ifdef TX_SEQ_SYNC_WORD_EN
         sync_cnt_q <= sync_cnt_d;
`endif
      end
   end

endmodule

// File: tb/tb_tx_frame_sequencer.sv
// -----------------------------------------------------------------------------
// tb_tx_frame_sequencer
//
// Directed bench for tx_frame_sequencer: a one-cycle-latency RAM model, a
// negedge monitor recording accepted bytes, RAM reads and done pulses, and a
// linear sequence of frames with hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_tx_frame_sequencer;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       i_transmit;
   logic [9:0] i_msg_length;
   logic       i_host_ram_req;
   logic       o_ram_rd;
   logic [9:0] o_ram_addr;
   logic [7:0] i_ram_data;
   logic [7:0] o_byte;
   logic       o_byte_valid;
   logic       i_byte_ready;
   logic       o_tx_done;
   logic       o_busy;

   logic [7:0] mem [0:1023];
   logic [7:0] acc [$];
   int         rd_cnt, done_cnt;
   logic [9:0] last_addr;
   logic       overlap;
   logic       rd_s;
   logic [9:0] addr_s;
   int         checks, errors;
   int         cyc, bad;

   tx_frame_sequencer dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .i_transmit     (i_transmit),
      .i_msg_length   (i_msg_length),
      .i_host_ram_req (i_host_ram_req),
      .o_ram_rd       (o_ram_rd),
      .o_ram_addr     (o_ram_addr),
      .i_ram_data     (i_ram_data),
      .o_byte         (o_byte),
      .o_byte_valid   (o_byte_valid),
      .i_byte_ready   (i_byte_ready),
      .o_tx_done      (o_tx_done),
      .o_busy         (o_busy)
   );

   always #5 clk = ~clk;

   // Monitor at negedge: inputs and DUT outputs are settled and stable here.
   always @(negedge clk) begin
      rd_s   = o_ram_rd;
      addr_s = o_ram_addr;
      if (o_byte_valid && i_byte_ready) acc.push_back(o_byte);
      if (o_ram_rd) begin
         rd_cnt++;
         last_addr = o_ram_addr;
      end
      if (o_tx_done) done_cnt++;
      if (o_ram_rd && o_byte_valid) overlap = 1'b1;
   end

   // RAM model: data is available the cycle after the read strobe.
   always @(posedge clk) begin
      if (!reset_n)  i_ram_data <= 8'h00;
      else if (rd_s) i_ram_data <= mem[addr_s];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic clear_stats();
      acc.delete();
      rd_cnt   = 0;
      done_cnt = 0;
   endtask

   // Advance until o_tx_done is seen or the budget runs out.
   task automatic run_to_done(input int budget, output int cycles);
      cycles = 0;
      while (!o_tx_done && cycles < budget) begin
         tick();
         cycles++;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      checks = 0; errors = 0; overlap = 1'b0;
      rd_s = 1'b0; addr_s = '0; last_addr = '0;
      clear_stats();
      for (int i = 0; i < 1024; i++) mem[i] = 8'(i * 7 + 3);
      reset_n        = 1'b0;
      i_transmit     = 1'b0;
      i_msg_length   = '0;
      i_host_ram_req = 1'b0;
      i_byte_ready   = 1'b1;

      // Reset state
      #12;
      check("rst_busy",  o_busy,       1'b0);
      check("rst_rd",    o_ram_rd,     1'b0);
      check("rst_addr",  o_ram_addr,   10'd0);
      check("rst_valid", o_byte_valid, 1'b0);
      check("rst_done",  o_tx_done,    1'b0);
      check("rst_byte",  o_byte,       8'h00);
      reset_n = 1'b1;
      tick();

`ifndef TX_SEQ_SYNC_WORD_EN
      // Frame 1: len=3, ready high, 11/22/33
      mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33;
      i_msg_length = 10'd3;
      i_transmit   = 1'b1;
      tick();                                     // cycle N+1
      check("t1_fetch_rd",   o_ram_rd,     1'b1);
      check("t1_fetch_addr", o_ram_addr,   10'd0);
      check("t1_busy",       o_busy,       1'b1);
      tick();                                     // N+2
      check("t1_wait_rd",    o_ram_rd,     1'b0);
      check("t1_wait_valid", o_byte_valid, 1'b0);
      tick();                                     // N+3
      check("t1_valid",      o_byte_valid, 1'b1);
      check("t1_byte0",      o_byte,       8'h11);
      run_to_done(40, cyc);
      check("t1_done_cycle", cyc + 3,      10);
      tick();
      check("t1_done_width", o_tx_done,    1'b0);
      check("t1_idle",       o_busy,       1'b0);
      tick(); tick();
      check("t1_no_rearm",   o_busy,       1'b0);
      check("t1_nbytes",     acc.size(),   3);
      check("t1_b0",         acc[0],       8'h11);
      check("t1_b1",         acc[1],       8'h22);
      check("t1_b2",         acc[2],       8'h33);
      check("t1_done_cnt",   done_cnt,     1);

      // Frame 2: len=2, host holds the port for the first 4 FETCH cycles
      i_transmit = 1'b0;
      tick();
      clear_stats();
      mem[0] = 8'hA1; mem[1] = 8'hB2;
      i_msg_length   = 10'd2;
      i_host_ram_req = 1'b1;
      i_transmit     = 1'b1;
      tick();                                     // N+1
      for (int k = 0; k < 4; k++) begin
         check("t2_host_blocks_rd", o_ram_rd, 1'b0);
         if (k < 3) tick();
      end
      tick();                                     // N+5
      i_host_ram_req = 1'b0;
      #1;
      check("t2_rd_after_host", o_ram_rd,   1'b1);
      check("t2_addr0",         o_ram_addr, 10'd0);
      tick(); tick();                             // N+7
      check("t2_valid_delayed", o_byte_valid, 1'b1);
      check("t2_byte0",         o_byte,       8'hA1);
      run_to_done(40, cyc);
      tick();
      check("t2_nbytes",   acc.size(), 2);
      check("t2_b0",       acc[0],     8'hA1);
      check("t2_b1",       acc[1],     8'hB2);
      check("t2_rd_cnt",   rd_cnt,     2);
      check("t2_done_cnt", done_cnt,   1);

      // Frame 3: ready low for 5 cycles while presenting 0xAB
      i_transmit = 1'b0;
      tick();
      clear_stats();
      mem[0] = 8'hAB;
      i_msg_length = 10'd1;
      i_byte_ready = 1'b0;
      i_transmit   = 1'b1;
      tick(); tick(); tick();                     // N+3
      for (int k = 0; k < 5; k++) begin
         check("t3_hold_valid", o_byte_valid, 1'b1);
         check("t3_hold_byte",  o_byte,       8'hAB);
         tick();
      end
      i_byte_ready = 1'b1;                        // N+8
      #1;
      check("t3_accept_valid", o_byte_valid, 1'b1);
      tick();                                     // N+9
      check("t3_done",     o_tx_done,  1'b1);
      tick();
      check("t3_nbytes",   acc.size(), 1);
      check("t3_b0",       acc[0],     8'hAB);

      // Frame 4: abort while presenting byte 2 of 5, then restart from 0
      i_transmit = 1'b0;
      tick();
      clear_stats();
      for (int i = 0; i < 5; i++) mem[i] = 8'(8'hC0 + i);
      i_msg_length = 10'd5;
      i_transmit   = 1'b1;
      tick(); tick(); tick(); tick(); tick(); tick(); // N+6
      check("t4_present_b1", o_byte,       8'hC1);
      check("t4_valid_b1",   o_byte_valid, 1'b1);
      i_transmit = 1'b0;
      #1;
      check("t4_abort_valid_drop", o_byte_valid, 1'b0);
      tick();
      check("t4_abort_idle", o_busy, 1'b0);
      tick(); tick();
      check("t4_no_done",    done_cnt,   0);
      check("t4_nbytes",     acc.size(), 1);
      clear_stats();
      i_transmit = 1'b1;
      tick();
      check("t4_restart_rd",   o_ram_rd,   1'b1);
      check("t4_restart_addr", o_ram_addr, 10'd0);
      run_to_done(60, cyc);
      tick();
      check("t4_re_nbytes",  acc.size(), 5);
      check("t4_re_b0",      acc[0],     8'hC0);
      check("t4_re_b4",      acc[4],     8'hC4);
      check("t4_re_done",    done_cnt,   1);

      // Frame 5: len=0 -> done at N+1, no reads, no bytes
      i_transmit = 1'b0;
      tick();
      clear_stats();
      i_msg_length = 10'd0;
      i_transmit   = 1'b1;
      tick();
      check("t5_len0_done", o_tx_done, 1'b1);
      check("t5_len0_rd",   o_ram_rd,  1'b0);
      tick();
      check("t5_len0_idle",  o_busy,     1'b0);
      check("t5_len0_reads", rd_cnt,     0);
      check("t5_len0_bytes", acc.size(), 0);

      // Frame 6: len=1023 clamps to 1000 bytes
      i_transmit = 1'b0;
      tick();
      clear_stats();
      i_msg_length = 10'd1023;
      i_transmit   = 1'b1;
      run_to_done(4000, cyc);
      check("t6_cycles", cyc, 3001);
      tick();
      check("t6_reads",     rd_cnt,     1000);
      check("t6_last_addr", last_addr,  10'd999);
      check("t6_nbytes",    acc.size(), 1000);
      check("t6_done_cnt",  done_cnt,   1);
      bad = 0;
      for (int i = 0; i < 1000; i++) if (acc[i] !== mem[i]) bad++;
      check("t6_data", bad, 0);
`else
      // Sync preamble: len=1 -> D3, 91, RAM[0], done; held level no restart
      mem[0] = 8'h5E;
      i_msg_length = 10'd1;
      i_transmit   = 1'b1;
      tick();                                     // N+1 SYNC
      check("s_sync_valid", o_byte_valid, 1'b0);
      check("s_busy",       o_busy,       1'b1);
      tick();                                     // N+2
      check("s_b0_valid", o_byte_valid, 1'b1);
      check("s_b0",       o_byte,       8'hD3);
      check("s_b0_rd",    o_ram_rd,     1'b0);
      tick(); tick();                             // N+4
      check("s_b1",       o_byte,       8'h91);
      tick();                                     // N+5
      check("s_fetch_rd",   o_ram_rd,   1'b1);
      check("s_fetch_addr", o_ram_addr, 10'd0);
      run_to_done(50, cyc);
      check("s_done_cycle", cyc, 3);
      tick(); tick(); tick();
      check("s_no_rearm",  o_busy,     1'b0);
      check("s_done_cnt",  done_cnt,   1);
      check("s_nbytes",    acc.size(), 3);
      check("s_acc0",      acc[0],     8'hD3);
      check("s_acc1",      acc[1],     8'h91);
      check("s_acc2",      acc[2],     8'h5E);
      check("s_reads",     rd_cnt,     1);
`endif

      check("rd_valid_overlap", overlap, 1'b0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
